mem_port_arbiter: RTL and testbench

//   Shares one single-ported memory between the CPU instruction-fetch port (pc_addr/pc_data)
//   and its load/store data port (rd_addr/wr_addr/wr_data/wr_valid).

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_timer.sv | 29 ++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DefaultAw = 32;
    localparam int unsigned DefaultDw = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntI = 2'd1,
        StGntD = 2'd2,
        StResp = 2'd3
    } arb_state_e;

    typedef enum logic {
        ReqFetch = 1'b0,
        ReqData  = 1'b1
    } req_id_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Clearable up-counter that saturates at MAX and flags when it sits at MAX.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic hit
);

    localparam int unsigned CountW = cnt_width(MAX);
    localparam logic [CountW-1:0] MaxVal = CountW'(MAX);

    logic [CountW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (incr && (cnt != MaxVal)) begin
            cnt <= cnt + CountW'(1);
        end
    end

    assign hit = (cnt == MaxVal);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the CPU fetch port and its load/store port,
// with starvation protection for fetch and a memory-ack timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = DefaultAw,
    parameter int unsigned DW         = DefaultDw,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic [DW-1:0] o_if_data,
    output logic          o_if_ack,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic [DW-1:0] o_d_rdata,
    output logic          o_d_ack,
    output logic          o_err,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_ack
);

    // The timeout counter compares its pre-increment value against TIMEOUT-1.
    localparam int unsigned TmoMax = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam bit          TmoEn  = (TIMEOUT != 0);

    arb_state_e    state;
    req_id_e       owner;
    logic          in_gnt;
    logic          grant_d;
    logic          grant_i;
    logic          starve_hit;
    logic          tmo_hit;
    logic          timed_out;
    logic          done;
    logic [DW-1:0] resp_data;

    always_comb begin
        in_gnt    = (state == StGntI) || (state == StGntD);
        grant_d   = (state == StIdle) && i_d_req && !(i_if_req && starve_hit);
        grant_i   = (state == StIdle) && i_if_req && !grant_d;
        timed_out = in_gnt && !i_mem_ack && TmoEn && tmo_hit;
        done      = in_gnt && (i_mem_ack || timed_out);
        resp_data = i_mem_ack ? i_mem_rdata : '0;
    end

    mem_arb_timer #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk  (clk),
        .reset(i_reset),
        .clear(grant_i),
        .incr (grant_d && i_if_req),
        .hit  (starve_hit)
    );

    mem_arb_timer #(
        .MAX(TmoMax)
    ) u_tmo (
        .clk  (clk),
        .reset(i_reset),
        .clear(grant_i || grant_d),
        .incr (in_gnt && !i_mem_ack),
        .hit  (tmo_hit)
    );

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state       <= StIdle;
            owner       <= ReqFetch;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_if_data   <= '0;
            o_if_ack    <= 1'b0;
            o_d_rdata   <= '0;
            o_d_ack     <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_if_ack <= 1'b0;
            o_d_ack  <= 1'b0;
            o_err    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grant_d) begin
                        state       <= StGntD;
                        owner       <= ReqData;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_d_we;
                        o_mem_addr  <= i_d_addr;
                        o_mem_wdata <= i_d_wdata;
                    end else if (grant_i) begin
                        state       <= StGntI;
                        owner       <= ReqFetch;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= 1'b0;
                        o_mem_addr  <= i_if_addr;
                        o_mem_wdata <= '0;
                    end
                end
                StGntI, StGntD: begin
                    if (done) begin
                        state     <= StResp;
                        o_mem_req <= 1'b0;
                        o_err     <= !i_mem_ack;
                        if (owner == ReqFetch) begin
                            o_if_ack  <= 1'b1;
                            o_if_data <= resp_data;
                        end else begin
                            o_d_ack   <= 1'b1;
                            o_d_rdata <= o_mem_we ? '0 : resp_data;
                        end
                    end
                end
                StResp: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level scoreboard and memory model.
module tb_mem_port_arbiter;

    localparam int StarveMax = 4;
    localparam int Timeout   = 16;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic [31:0] o_if_data;
    logic        o_if_ack;
    logic        i_d_req;
    logic        i_d_we;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic [31:0] o_d_rdata;
    logic        o_d_ack;
    logic        o_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Stimulus controls owned by the directed block, consumed by the driver.
    int rst_cycles = 2;
    int mem_wait   = 0;
    bit mem_dead   = 1'b0;
    bit force_ack  = 1'b0;

    logic [31:0] mem [logic [31:0]];
    txn_t if_todo[$], d_todo[$], if_issued[$], d_issued[$];
    int   if_ack_cyc[$], d_ack_cyc[$], if_raise_cyc[$], grant_log[$], len_log[$];
    bit   d_err_log[$];

    mem_port_arbiter #(
        .AW        (32),
        .DW        (32),
        .STARVE_MAX(StarveMax),
        .TIMEOUT   (Timeout)
    ) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_if_req   (i_if_req),
        .i_if_addr  (i_if_addr),
        .o_if_data  (o_if_data),
        .o_if_ack   (o_if_ack),
        .i_d_req    (i_d_req),
        .i_d_we     (i_d_we),
        .i_d_addr   (i_d_addr),
        .i_d_wdata  (i_d_wdata),
        .o_d_rdata  (o_d_rdata),
        .o_d_ack    (o_d_ack),
        .o_err      (o_err),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata),
        .i_mem_ack  (i_mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hC0DE_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_if(input logic [31:0] a);
        if_todo.push_back('{1'b0, a, 32'h0});
    endtask

    task automatic push_ld(input logic [31:0] a);
        d_todo.push_back('{1'b0, a, 32'h0});
    endtask

    task automatic push_st(input logic [31:0] a, input logic [31:0] d);
        d_todo.push_back('{1'b1, a, d});
    endtask

    task automatic clear_logs();
        if_ack_cyc.delete(); d_ack_cyc.delete(); if_raise_cyc.delete();
        grant_log.delete(); len_log.delete(); d_err_log.delete();
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = (if_todo.size() == 0) && (d_todo.size() == 0) && (if_issued.size() == 0) &&
                 (d_issued.size() == 0) && !i_if_req && !i_d_req && !o_mem_req;
        end
        chk(name, 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Requester agents and memory responder; all inputs change just after the falling edge.
    initial begin : driver
        int   wcnt;
        txn_t t;
        wcnt = 0;
        i_reset = 1'b1; i_if_req = 1'b0; i_if_addr = '0; i_d_req = 1'b0; i_d_we = 1'b0;
        i_d_addr = '0; i_d_wdata = '0; i_mem_rdata = '0; i_mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_cycles > 0) begin
                rst_cycles--;
                i_reset = 1'b1; i_if_req = 1'b0; i_d_req = 1'b0; i_mem_ack = 1'b0;
                if_todo.delete(); d_todo.delete();
                wcnt = 0;
            end else begin
                i_reset = 1'b0;
                if (force_ack) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = 32'h5A5A_5A5A;
                end else if (o_mem_req) begin
                    if (!mem_dead && wcnt == mem_wait) begin
                        i_mem_ack = 1'b1;
                        if (o_mem_we) begin
                            mem[o_mem_addr] = o_mem_wdata;
                            i_mem_rdata = 32'hBAD0_BAD0;
                        end else begin
                            i_mem_rdata = mem_rd(o_mem_addr);
                        end
                    end else begin
                        i_mem_ack   = 1'b0;
                        i_mem_rdata = $urandom;
                    end
                    wcnt++;
                end else begin
                    i_mem_ack   = 1'b0;
                    i_mem_rdata = $urandom;
                    wcnt = 0;
                end
                if (o_if_ack) i_if_req = 1'b0;
                if (!i_if_req && if_todo.size() > 0) begin
                    t = if_todo.pop_front();
                    i_if_addr = t.addr;
                    i_if_req  = 1'b1;
                    if_issued.push_back(t);
                    if_raise_cyc.push_back(cyc);
                end
                if (o_d_ack) i_d_req = 1'b0;
                if (!i_d_req && d_todo.size() > 0) begin
                    t = d_todo.pop_front();
                    i_d_we    = t.we;
                    i_d_addr  = t.addr;
                    i_d_wdata = t.wdata;
                    i_d_req   = 1'b1;
                    d_issued.push_back(t);
                end
            end
        end
    end

    // Scoreboard: who should win, what the memory must see, and what each ack must return.
    initial begin : compare
        bit          prev_req;
        int          len;
        int          side;
        int          starve;
        txn_t        cur;
        txn_t        done_t;
        logic [31:0] exp_if;
        logic [31:0] exp_d;
        logic [31:0] exp_val;
        prev_req = 1'b0; len = 0; side = 0; starve = 0; cur = '0;
        exp_if = '0; exp_d = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (i_reset) begin
                chk("rst_mem_req", 32'(o_mem_req), 32'd0);
                chk("rst_acks", 32'({o_if_ack, o_d_ack, o_err}), 32'd0);
                chk("rst_mem_addr", o_mem_addr, 32'd0);
                chk("rst_mem_wdata_we", o_mem_wdata | 32'(o_mem_we), 32'd0);
                chk("rst_rdata", o_if_data | o_d_rdata, 32'd0);
                prev_req = 1'b0; starve = 0; exp_if = '0; exp_d = '0;
                if_issued.delete(); d_issued.delete();
            end else begin
                if (prev_req && !o_mem_req) begin
                    len_log.push_back(len);
                    chk("req_len", 32'(len), mem_dead ? 32'(Timeout) : 32'(mem_wait + 1));
                    exp_val = mem_dead ? 32'h0 : mem_rd(cur.addr);
                    if (side == 0) begin
                        exp_if = exp_val;
                        chk("if_ack_pulse", 32'({o_if_ack, o_d_ack}), 32'd2);
                        if (if_issued.size() > 0) done_t = if_issued.pop_front();
                        if_ack_cyc.push_back(cyc);
                    end else begin
                        exp_d = cur.we ? 32'h0 : exp_val;
                        chk("d_ack_pulse", 32'({o_if_ack, o_d_ack}), 32'd1);
                        if (d_issued.size() > 0) done_t = d_issued.pop_front();
                        d_ack_cyc.push_back(cyc);
                        d_err_log.push_back(o_err);
                    end
                    chk("ack_err", 32'(o_err), 32'(mem_dead));
                end else begin
                    chk("no_ack", 32'({o_if_ack, o_d_ack, o_err}), 32'd0);
                end
                chk("if_data", o_if_data, exp_if);
                chk("d_rdata", o_d_rdata, exp_d);
                if (o_mem_req && !prev_req) begin
                    if (i_d_req && !(i_if_req && starve == StarveMax)) begin
                        side = 1;
                        if (i_if_req && starve < StarveMax) starve++;
                    end else begin
                        side = 0;
                        starve = 0;
                    end
                    chk("grant_has_req", 32'(side == 1 ? d_issued.size() : if_issued.size()) != 0,
                        32'd1);
                    cur = '0;
                    if (side == 1 && d_issued.size() > 0) cur = d_issued[0];
                    if (side == 0 && if_issued.size() > 0) cur = if_issued[0];
                    len = 0;
                    grant_log.push_back(side);
                end
                if (o_mem_req) begin
                    len++;
                    chk("mem_addr", o_mem_addr, cur.addr);
                    chk("mem_we", 32'(o_mem_we), 32'(cur.we));
                    if (cur.we) chk("mem_wdata", o_mem_wdata, cur.wdata);
                end
                prev_req = o_mem_req;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : directed
        int n;
        @(posedge clk);
        #2;
        chk("t0_reset_req", 32'(o_mem_req), 32'd0);
        chk("t0_reset_ack", 32'({o_if_ack, o_d_ack}), 32'd0);
        repeat (4) @(negedge clk);

        // Zero-wait fetch: ack two cycles after the request is first seen.
        mem[32'h10] = 32'hE3A0_1005;
        mem_wait = 0;
        clear_logs();
        push_if(32'h10);
        wait_idle("t1_idle");
        chk("t1_acks", 32'(if_ack_cyc.size()), 32'd1);
        if (if_ack_cyc.size() == 1)
            chk("t1_latency", 32'(if_ack_cyc[0] - if_raise_cyc[0]), 32'd2);
        chk("t1_if_data", o_if_data, 32'hE3A0_1005);
        chk("t1_addr_kept", o_mem_addr, 32'h10);

        // Simultaneous store and fetch: the store goes first.
        mem[32'h04] = 32'h1111_2222;
        clear_logs();
        push_st(32'h20, 32'hDEAD_BEEF);
        push_if(32'h04);
        wait_idle("t2_idle");
        chk("t2_first_grant_data", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);
        chk("t2_store_mem", mem_rd(32'h20), 32'hDEAD_BEEF);
        if (if_ack_cyc.size() == 1 && d_ack_cyc.size() == 1)
            chk("t2_fetch_gap", 32'(if_ack_cyc[0] - d_ack_cyc[0]), 32'd3);
        else
            chk("t2_ack_counts", 32'(if_ack_cyc.size() + d_ack_cyc.size()), 32'd2);
        chk("t2_if_data", o_if_data, 32'h1111_2222);
        chk("t2_store_rdata", o_d_rdata, 32'h0);
        push_ld(32'h20);
        wait_idle("t2_load_idle");
        chk("t2_load_back", o_d_rdata, 32'hDEAD_BEEF);

        // Data held continuously with fetch pending: four data grants, then fetch.
        clear_logs();
        for (int i = 0; i < 6; i++) push_ld(32'h100 + 32'(4 * i));
        push_if(32'h40);
        wait_idle("t3_idle");
        chk("t3_grants", 32'(grant_log.size()), 32'd7);
        chk("t3_if_acks", 32'(if_ack_cyc.size()), 32'd1);
        if (if_ack_cyc.size() == 1) begin
            n = 0;
            foreach (d_ack_cyc[i]) if (d_ack_cyc[i] < if_ack_cyc[0]) n++;
            chk("t3_data_before_fetch", 32'(n), 32'd4);
        end
        chk("t3_last_rdata", o_d_rdata, 32'hC0DE_0114);

        // Dead memory: timeout after sixteen request cycles, error with zero data.
        clear_logs();
        mem_dead = 1'b1;
        push_ld(32'h30);
        wait_idle("t4_idle");
        mem_dead = 1'b0;
        chk("t4_len", 32'(len_log.size() > 0 ? len_log[0] : 0), 32'd16);
        chk("t4_err", 32'(d_err_log.size() > 0 ? d_err_log[0] : 1'b0), 32'd1);
        chk("t4_rdata", o_d_rdata, 32'h0);

        // Reset in the middle of a data grant, then a stale ack.
        clear_logs();
        mem_wait = 6;
        push_ld(32'h50);
        n = 0;
        while (!o_mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_granted", 32'(o_mem_req), 32'd1);
        @(negedge clk);
        rst_cycles = 1;
        @(posedge clk);
        #2;
        chk("t5_req_dropped", 32'(o_mem_req), 32'd0);
        chk("t5_no_ack", 32'(o_d_ack), 32'd0);
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_no_late_ack", 32'(d_ack_cyc.size()), 32'd0);
        chk("t5_no_regrant", 32'(grant_log.size()), 32'd1);
        chk("t5_idle_req", 32'(o_mem_req), 32'd0);

        // Three wait states, back-to-back fetches.
        clear_logs();
        mem_wait = 3;
        push_if(32'h0);
        push_if(32'h4);
        push_if(32'h8);
        wait_idle("t6_idle");
        chk("t6_acks", 32'(if_ack_cyc.size()), 32'd3);
        if (if_ack_cyc.size() == 3) begin
            chk("t6_latency", 32'(if_ack_cyc[0] - if_raise_cyc[0]), 32'd5);
            chk("t6_spacing1", 32'(if_ack_cyc[1] - if_ack_cyc[0]), 32'd6);
            chk("t6_spacing2", 32'(if_ack_cyc[2] - if_ack_cyc[1]), 32'd6);
        end
        chk("t6_if_data", o_if_data, 32'hC0DE_0008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
